// File: rtl/sys_skew_feeder.sv
// Skewing feeder for a systolic array: row r of each accepted beat reaches feat_out
// r advances after the beat was accepted, with a zero-injecting flush after the block.
module sys_skew_feeder #(
   parameter int dataWidth    = 32,
   parameter int SysDimension = 32,
   parameter int featureLen   = 128
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               start,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [SysDimension*dataWidth-1:0]  in_data,
   output logic [SysDimension*dataWidth-1:0]  feat_out,
   output logic                               array_en,
   output logic                               busy,
   output logic                               done
);

   localparam int BW = $clog2(featureLen);
   localparam int FW = (SysDimension > 2) ? $clog2(SysDimension - 1) : 1;
   localparam logic [BW-1:0] BEAT_LAST  = BW'(featureLen - 1);
   localparam logic [FW-1:0] FLUSH_LAST = FW'((SysDimension > 1) ? SysDimension - 2 : 0);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FEED,
      S_FLUSH
   } t_state;

   t_state          r_state;
   t_state          w_state_nxt;
   logic [BW-1:0]   r_beat_cnt;
   logic [BW-1:0]   w_beat_nxt;
   logic [FW-1:0]   r_flush_cnt;
   logic [FW-1:0]   w_flush_nxt;
   logic            w_accept;
   logic            w_advance;
   logic            w_last_adv;
   logic            w_inject;
   logic            r_array_en;
   logic            r_done;

   assign in_ready  = (r_state == S_FEED);
   assign busy      = (r_state != S_IDLE);
   assign w_accept  = in_valid & in_ready;
   assign w_advance = w_accept | (r_state == S_FLUSH);
   // Flush cycles push zeros so every row drains cleanly behind its last beat.
   assign w_inject  = (r_state == S_FEED);
   assign array_en  = r_array_en;
   assign done      = r_done;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_beat_cnt  <= '0;
         r_flush_cnt <= '0;
         r_array_en  <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_beat_cnt  <= w_beat_nxt;
         r_flush_cnt <= w_flush_nxt;
         r_array_en  <= w_advance;
         r_done      <= w_last_adv;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_beat_nxt  = r_beat_cnt;
      w_flush_nxt = r_flush_cnt;
      w_last_adv  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) w_state_nxt = S_FEED;
         end
         S_FEED: begin
            if (w_accept) begin
               if (r_beat_cnt == BEAT_LAST) begin
                  w_beat_nxt = '0;
                  // A single-row array has nothing to drain, so the block ends here.
                  if (SysDimension == 1) begin
                     w_state_nxt = S_IDLE;
                     w_last_adv  = 1'b1;
                  end else begin
                     w_state_nxt = S_FLUSH;
                  end
               end else begin
                  w_beat_nxt = r_beat_cnt + 1'b1;
               end
            end
         end
         S_FLUSH: begin
            if (r_flush_cnt == FLUSH_LAST) begin
               w_flush_nxt = '0;
               w_state_nxt = S_IDLE;
               w_last_adv  = 1'b1;
            end else begin
               w_flush_nxt = r_flush_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   for (genvar r = 0; r < SysDimension; r++) begin : g_row
      logic [dataWidth-1:0] w_inj;
      logic [dataWidth-1:0] r_feat;

      assign w_inj = w_inject ? in_data[r*dataWidth +: dataWidth] : '0;
      assign feat_out[r*dataWidth +: dataWidth] = r_feat;

      if (r == 0) begin : g_nodly
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               r_feat <= '0;
            end else if (w_advance) begin
               r_feat <= w_inj;
            end
         end
      end else begin : g_dly
         // r-deep shift line; only advances move it, so stalls freeze the skew.
         logic [dataWidth-1:0] r_dly [r];

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               for (int i = 0; i < r; i++) r_dly[i] <= '0;
               r_feat <= '0;
            end else if (w_advance) begin
               r_dly[0] <= w_inj;
               for (int i = 1; i < r; i++) r_dly[i] <= r_dly[i-1];
               r_feat <= r_dly[r-1];
            end
         end
      end
   end

endmodule
